// File: rtl/mem_req_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_req_arbiter: round-robin merge of per-client cache-line requests     |
// | onto one strobe/done memory port.                      Revision: 1.0     |
// +--------------------------------------------------------------------------+
module mem_req_arbiter #(
  parameter  int N_CLIENTS  = 4,
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 128,
  localparam int GW         = $clog2(N_CLIENTS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N_CLIENTS-1:0]             req_i,
  input  logic [N_CLIENTS-1:0]             rw_i,
  input  logic [N_CLIENTS*ADDR_WIDTH-1:0]  addr_i,
  input  logic [N_CLIENTS*DATA_WIDTH-1:0]  wdata_i,
  output logic [DATA_WIDTH-1:0]            rdata_o,
  output logic [N_CLIENTS-1:0]             done_o,
  output logic                             strobe_o,
  output logic [ADDR_WIDTH-1:0]            addr_o,
  output logic [DATA_WIDTH-1:0]            wdata_o,
  output logic                             rw_o,
  input  logic [DATA_WIDTH-1:0]            rdata_i,
  input  logic                             done_i,
  output logic                             busy_o,
  output logic [GW-1:0]                    grant_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t                  state_q;
  logic [GW-1:0]           rr_q;
  logic [GW-1:0]           grant_q;
  logic                    strobe_q;
  logic                    busy_q;
  logic                    rw_q;
  logic [N_CLIENTS-1:0]    done_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;

  logic [ADDR_WIDTH-1:0]   addr_a  [N_CLIENTS];
  logic [DATA_WIDTH-1:0]   wdata_a [N_CLIENTS];

  generate
    for (genvar k = 0; k < N_CLIENTS; k++) begin : g_unpack
      assign addr_a[k]  = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_a[k] = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Scan clients starting at rr_q with wrap-around; first requester wins.
  logic [GW-1:0] pick_idx;
  logic          pick_vld;
  logic [GW:0]   cand;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      cand = {1'b0, rr_q} + (GW+1)'(i);
      if (cand >= (GW+1)'(N_CLIENTS)) cand = cand - (GW+1)'(N_CLIENTS);
      if (!pick_vld && req_i[cand[GW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[GW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      grant_q  <= '0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      rw_q     <= 1'b0;
      done_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      strobe_q <= 1'b0;
      done_q   <= '0;
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            grant_q  <= pick_idx;
            addr_q   <= addr_a[pick_idx];
            wdata_q  <= wdata_a[pick_idx];
            rw_q     <= rw_i[pick_idx];
            strobe_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= REQ;
          end
        end
        REQ: state_q <= WAIT;
        WAIT: begin
          if (done_i) begin
            if (!rw_q) rdata_q <= rdata_i;
            done_q  <= N_CLIENTS'(1) << grant_q;
            state_q <= RESP;
          end
        end
        RESP: begin
          // Last-served client drops to lowest priority.
          rr_q    <= (grant_q == GW'(N_CLIENTS-1)) ? '0 : grant_q + 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rdata_o  = rdata_q;
  assign done_o   = done_q;
  assign strobe_o = strobe_q;
  assign addr_o   = addr_q;
  assign wdata_o  = wdata_q;
  assign rw_o     = rw_q;
  assign busy_o   = busy_q;
  assign grant_o  = grant_q;

endmodule
`default_nettype wire

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Round-robin arbiter that merges cache-line memory requests from N per-core clients onto the single strobe/done data-memory port of the simulation RAM. Each client issues one outstanding request at a time. The winner's address, write data and direction are latched and presented downstream for the whole transaction. The returned line is registered and handed back to the winning client with a one-cycle done pulse. The block sits between the per-core D-cache miss logic and the dmem port of the memory model in the Verilator testbench.

## Interface
- N_CLIENTS, 4: number of requesting clients (2..8).
- ADDR_WIDTH, 32: byte address width.
- DATA_WIDTH, 128: cache-line width; multiple of 32.
- GW, $clog2(N_CLIENTS): grant index width (derived, not overridable).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- req_i  in  N_CLIENTS  per-client request level.
- rw_i  in  N_CLIENTS  per-client direction: 1 = write, 0 = read.
- addr_i  in  N_CLIENTS*ADDR_WIDTH  packed addresses; client k occupies [k*ADDR_WIDTH +: ADDR_WIDTH].
- wdata_i  in  N_CLIENTS*DATA_WIDTH  packed write lines, same packing.
- rdata_o  out  DATA_WIDTH  registered read line, shared by all clients.
- done_o  out  N_CLIENTS  one-hot, one-cycle completion pulse.
- strobe_o  out  1  downstream request pulse.
- addr_o  out  ADDR_WIDTH  latched address, passed through unmodified.
- wdata_o  out  DATA_WIDTH  latched write line.
- rw_o  out  1  latched direction.
- rdata_i  in  DATA_WIDTH  downstream read line, valid while done_i=1.
- done_i  in  1  downstream completion.
- busy_o  out  1  high in every state except IDLE.
- grant_o  out  GW  index of the current or last-served client.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - If any req_i bit is set, choose the winner by round-robin starting at rr_ptr.
  - Latch the winner's addr, wdata and rw into addr_o, wdata_o and rw_o; load grant_o.
  - Go to REQ.
  - With no request, stay in IDLE.
- REQ: strobe_o=1 for exactly this cycle; go to WAIT.
- WAIT:
  - Hold all latched outputs stable.
  - On done_i=1: capture rdata_i into rdata_o (reads only; writes leave rdata_o unchanged) and go to RESP.
- RESP:
  - done_o[grant_o]=1 for this cycle only.
  - rr_ptr <= (grant_o+1) mod N_CLIENTS.
  - Go to IDLE.
  - req_i is not sampled in RESP.
- Round-robin: the lowest index at or after rr_ptr, with wrap-around, wins. After serving client k, client k has the lowest priority.
- Client contract:
  - Hold req_i and the request fields until done_o.
  - Deassert req_i no later than the cycle after done_o.
  - The arbiter latches the fields, so changes after grant have no effect on the transaction in flight.
- done_i outside WAIT is ignored.
- There is no internal timeout; a missing done_i keeps the FSM in WAIT indefinitely.

## Timing
- Reset values: state IDLE, rr_ptr 0, and all of strobe_o, done_o, busy_o, grant_o, addr_o, wdata_o, rw_o, rdata_o are 0.
- Reset asserted mid-transaction returns the FSM to IDLE on the next edge and drops strobe_o and done_o. Any downstream transaction in flight is abandoned.
- Request sampled in IDLE at cycle 0: REQ (strobe_o) at cycle 1.
- If the downstream raises done_i L cycles after strobe, RESP/done_o falls at cycle L+2.
- Minimum gap between consecutive strobe_o pulses: L+3 cycles. The RESP and IDLE cycles guarantee a downstream that spends one post-done cycle before accepting a new strobe never misses a pulse.
- rdata_o is valid from the RESP cycle onward and holds until the next completed read.
- strobe_o and done_o are never high simultaneously.

## Test plan
- Single read: client 2 reads 0x8000_0040 with the model returning 0x0123…CDEF, done_i 5 cycles after strobe -> strobe_o at cycle 1, done_o=4'b0100 at cycle 7, rdata_o=0x0123…CDEF, grant_o=2.
- Single write: client 0 writes 0xA5A5…A5A5 to 0x8000_0100 -> rw_o=1, addr_o and wdata_o stable from REQ through RESP, done_o=4'b0001, rdata_o unchanged.
- Fairness: all 4 clients hold req_i continuously and re-request immediately -> grant order 0,1,2,3,0,1. No client is served twice before all others are served once.
- Wrap priority: serve client 3, then clients 0 and 3 request together -> client 0 wins.
- Field change after grant: client 1 changes addr_i from 0x8000_0000 to 0x8000_1000 during WAIT -> addr_o stays 0x8000_0000 until done_o.
- Reset mid-WAIT: assert rst_n=0 for 1 cycle while in WAIT -> all outputs 0 and state IDLE on the next cycle, with no done_o pulse. A later done_i is ignored, and the next request is served normally with rr_ptr=0.
